// File: rtl/hsv_pkg.sv
// Constants and types shared by the HSV pixel pipeline: the RGB-to-HSV converter
// and the ball centroid accumulator.
package hsv_pkg;

    localparam int unsigned HUE_W = 9;
    localparam int unsigned SV_W  = 5;
    localparam int unsigned X_W   = 10;
    localparam int unsigned Y_W   = 9;
    localparam int unsigned CNT_W = 19;
    localparam int unsigned SUM_W = 29;

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StPublish
    } state_e;

    // A window with lo > hi wraps through hue 0 (e.g. red).
    function automatic logic hue_in_window(input logic [HUE_W-1:0] hue,
                                           input logic [HUE_W-1:0] lo,
                                           input logic [HUE_W-1:0] hi);
        if (lo <= hi) begin
            return (hue >= lo) && (hue <= hi);
        end
        return (hue >= lo) || (hue <= hi);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, N cycles from i_start to o_done.
// A new i_start while busy abandons the current division.
module seq_divider #(
    parameter int unsigned N  = 29,
    parameter int unsigned QW = N
) (
    input  logic          i_clk,
    input  logic          i_res,
    input  logic          i_start,
    input  logic [N-1:0]  i_dividend,
    input  logic [N-1:0]  i_divisor,
    output logic [QW-1:0] o_quotient,
    output logic          o_done
);

    localparam int unsigned CW = $clog2(N + 1);

    logic [N-1:0]  r_rem;
    logic [N-1:0]  r_quo;
    logic [N-1:0]  r_div;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic [N:0]    w_trial;
    logic [N:0]    w_diff;

    // Remainder stays below the divisor, so the shifted trial value fits in N+1 bits.
    always_comb begin
        w_trial = {r_rem, r_quo[N-1]};
        w_diff  = w_trial - {1'b0, r_div};
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= '0;
                r_quo  <= i_dividend;
                r_div  <= i_divisor;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (w_diff[N]) begin
                    r_rem <= w_trial[N-1:0];
                    r_quo <= {r_quo[N-2:0], 1'b0};
                end else begin
                    r_rem <= w_diff[N-1:0];
                    r_quo <= {r_quo[N-2:0], 1'b1};
                end
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == CW'(N - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_quotient = r_quo[QW-1:0];
    assign o_done     = r_done;

endmodule

// File: rtl/ball_centroid_acc.sv
// Classifies HSV pixels against a programmable window, accumulates count, coordinate sums
// and bounding box per frame, and publishes one centroid result per frame.
module ball_centroid_acc #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned X_W       = hsv_pkg::X_W,
    parameter int unsigned Y_W       = hsv_pkg::Y_W,
    parameter int unsigned CNT_W     = hsv_pkg::CNT_W,
    parameter int unsigned SUM_W     = hsv_pkg::SUM_W,
    parameter int unsigned MIN_COUNT = 16
) (
    input  logic                      i_clk,
    input  logic                      i_res,
    input  logic                      i_frame_sync,
    input  logic                      i_pix_valid,
    input  logic [hsv_pkg::HUE_W-1:0] i_hue,
    input  logic [hsv_pkg::SV_W-1:0]  i_saturation,
    input  logic [hsv_pkg::SV_W-1:0]  i_value,
    input  logic                      i_hue_invalid,
    input  logic [hsv_pkg::HUE_W-1:0] i_hue_min,
    input  logic [hsv_pkg::HUE_W-1:0] i_hue_max,
    input  logic [hsv_pkg::SV_W-1:0]  i_sat_min,
    input  logic [hsv_pkg::SV_W-1:0]  i_val_min,
    output logic                      o_result_valid,
    output logic                      o_ball_found,
    output logic [X_W-1:0]            o_ball_x,
    output logic [Y_W-1:0]            o_ball_y,
    output logic [CNT_W-1:0]          o_ball_count,
    output logic [X_W-1:0]            o_bbox_xmin,
    output logic [X_W-1:0]            o_bbox_xmax,
    output logic [Y_W-1:0]            o_bbox_ymin,
    output logic [Y_W-1:0]            o_bbox_ymax,
    output logic                      o_overrun
);

    import hsv_pkg::*;

    logic [X_W-1:0]   r_x, r_xmin, r_xmax, r_s_xmin, r_s_xmax;
    logic [Y_W-1:0]   r_y, r_ymin, r_ymax, r_s_ymin, r_s_ymax;
    logic [CNT_W-1:0] r_cnt, r_s_cnt;
    logic [SUM_W-1:0] r_sum_x, r_sum_y, r_s_sum_x, r_s_sum_y;
    logic             r_pending;
    state_e           r_state, w_state_d;

    logic             r_result_valid, r_ball_found, r_overrun;
    logic [X_W-1:0]   r_ball_x, r_bbox_xmin, r_bbox_xmax;
    logic [Y_W-1:0]   r_ball_y, r_bbox_ymin, r_bbox_ymax;
    logic [CNT_W-1:0] r_ball_count;

    logic [X_W-1:0]   w_px, w_xmin_b, w_xmax_b, w_x_n, w_xmin_n, w_xmax_n;
    logic [Y_W-1:0]   w_py, w_ymin_b, w_ymax_b, w_y_n, w_ymin_n, w_ymax_n;
    logic [CNT_W-1:0] w_cnt_b, w_cnt_n;
    logic [SUM_W-1:0] w_sum_x_b, w_sum_y_b, w_sum_x_n, w_sum_y_n;
    logic             w_match, w_frame_end;
    logic             w_div_start, w_consume, w_publish;
    logic             w_done_x, w_done_y, w_div_done;
    logic [X_W-1:0]   w_quo_x;
    logic [Y_W-1:0]   w_quo_y;

    // frame_sync clears first, so a coincident pixel lands on (0,0) of a fresh frame.
    always_comb begin
        w_px      = i_frame_sync ? '0 : r_x;
        w_py      = i_frame_sync ? '0 : r_y;
        w_cnt_b   = i_frame_sync ? '0 : r_cnt;
        w_sum_x_b = i_frame_sync ? '0 : r_sum_x;
        w_sum_y_b = i_frame_sync ? '0 : r_sum_y;
        w_xmin_b  = i_frame_sync ? '0 : r_xmin;
        w_xmax_b  = i_frame_sync ? '0 : r_xmax;
        w_ymin_b  = i_frame_sync ? '0 : r_ymin;
        w_ymax_b  = i_frame_sync ? '0 : r_ymax;

        w_match = i_pix_valid && !i_hue_invalid && (i_saturation >= i_sat_min) &&
                  (i_value >= i_val_min) && hue_in_window(i_hue, i_hue_min, i_hue_max);
        w_frame_end = i_pix_valid && (w_px == X_W'(H_ACTIVE - 1)) &&
                      (w_py == Y_W'(V_ACTIVE - 1));

        w_cnt_n   = w_cnt_b;
        w_sum_x_n = w_sum_x_b;
        w_sum_y_n = w_sum_y_b;
        w_xmin_n  = w_xmin_b;
        w_xmax_n  = w_xmax_b;
        w_ymin_n  = w_ymin_b;
        w_ymax_n  = w_ymax_b;
        if (w_match) begin
            w_cnt_n   = w_cnt_b + CNT_W'(1);
            w_sum_x_n = w_sum_x_b + SUM_W'(w_px);
            w_sum_y_n = w_sum_y_b + SUM_W'(w_py);
            if (w_cnt_b == '0) begin
                w_xmin_n = w_px;
                w_xmax_n = w_px;
                w_ymin_n = w_py;
                w_ymax_n = w_py;
            end else begin
                if (w_px < w_xmin_b) w_xmin_n = w_px;
                if (w_px > w_xmax_b) w_xmax_n = w_px;
                if (w_py < w_ymin_b) w_ymin_n = w_py;
                if (w_py > w_ymax_b) w_ymax_n = w_py;
            end
        end

        w_x_n = w_px;
        w_y_n = w_py;
        if (i_pix_valid) begin
            if (w_px == X_W'(H_ACTIVE - 1)) begin
                w_x_n = '0;
                w_y_n = (w_py == Y_W'(V_ACTIVE - 1)) ? '0 : w_py + Y_W'(1);
            end else begin
                w_x_n = w_px + X_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_x       <= '0;
            r_y       <= '0;
            r_cnt     <= '0;
            r_sum_x   <= '0;
            r_sum_y   <= '0;
            r_xmin    <= '0;
            r_xmax    <= '0;
            r_ymin    <= '0;
            r_ymax    <= '0;
            r_s_cnt   <= '0;
            r_s_sum_x <= '0;
            r_s_sum_y <= '0;
            r_s_xmin  <= '0;
            r_s_xmax  <= '0;
            r_s_ymin  <= '0;
            r_s_ymax  <= '0;
            r_pending <= 1'b0;
        end else begin
            r_x <= w_x_n;
            r_y <= w_y_n;
            if (w_frame_end) begin
                r_cnt     <= '0;
                r_sum_x   <= '0;
                r_sum_y   <= '0;
                r_xmin    <= '0;
                r_xmax    <= '0;
                r_ymin    <= '0;
                r_ymax    <= '0;
                r_s_cnt   <= w_cnt_n;
                r_s_sum_x <= w_sum_x_n;
                r_s_sum_y <= w_sum_y_n;
                r_s_xmin  <= w_xmin_n;
                r_s_xmax  <= w_xmax_n;
                r_s_ymin  <= w_ymin_n;
                r_s_ymax  <= w_ymax_n;
                r_pending <= 1'b1;
            end else begin
                r_cnt   <= w_cnt_n;
                r_sum_x <= w_sum_x_n;
                r_sum_y <= w_sum_y_n;
                r_xmin  <= w_xmin_n;
                r_xmax  <= w_xmax_n;
                r_ymin  <= w_ymin_n;
                r_ymax  <= w_ymax_n;
                if (w_consume) r_pending <= 1'b0;
            end
        end
    end

    assign w_div_done = w_done_x & w_done_y;

    // A fresh snapshot takes priority over a finishing division: the stale result is dropped.
    always_comb begin
        w_state_d   = r_state;
        w_div_start = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            StIdle, StDiv: begin
                if (r_pending) begin
                    w_consume = 1'b1;
                    if (r_s_cnt == '0) begin
                        w_state_d = StPublish;
                    end else begin
                        w_div_start = 1'b1;
                        w_state_d   = StDiv;
                    end
                end else if ((r_state == StDiv) && w_div_done) begin
                    w_state_d = StPublish;
                end
            end
            StPublish: w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
        w_publish = (w_state_d == StPublish) && (r_state != StPublish);
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state        <= StIdle;
            r_result_valid <= 1'b0;
            r_ball_found   <= 1'b0;
            r_ball_x       <= '0;
            r_ball_y       <= '0;
            r_ball_count   <= '0;
            r_bbox_xmin    <= '0;
            r_bbox_xmax    <= '0;
            r_bbox_ymin    <= '0;
            r_bbox_ymax    <= '0;
            r_overrun      <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_result_valid <= w_publish;
            if (w_publish) begin
                r_ball_found <= (r_s_cnt >= CNT_W'(MIN_COUNT));
                r_ball_count <= r_s_cnt;
                if (r_s_cnt == '0) begin
                    r_ball_x    <= '0;
                    r_ball_y    <= '0;
                    r_bbox_xmin <= '0;
                    r_bbox_xmax <= '0;
                    r_bbox_ymin <= '0;
                    r_bbox_ymax <= '0;
                end else begin
                    r_ball_x    <= w_quo_x;
                    r_ball_y    <= w_quo_y;
                    r_bbox_xmin <= r_s_xmin;
                    r_bbox_xmax <= r_s_xmax;
                    r_bbox_ymin <= r_s_ymin;
                    r_bbox_ymax <= r_s_ymax;
                end
            end
            if (w_frame_end && (r_state == StDiv) && !w_div_done) r_overrun <= 1'b1;
        end
    end

    seq_divider #(
        .N  (SUM_W),
        .QW (X_W)
    ) u_div_x (
        .i_clk      (i_clk),
        .i_res      (i_res),
        .i_start    (w_div_start),
        .i_dividend (r_s_sum_x),
        .i_divisor  (SUM_W'(r_s_cnt)),
        .o_quotient (w_quo_x),
        .o_done     (w_done_x)
    );

    seq_divider #(
        .N  (SUM_W),
        .QW (Y_W)
    ) u_div_y (
        .i_clk      (i_clk),
        .i_res      (i_res),
        .i_start    (w_div_start),
        .i_dividend (r_s_sum_y),
        .i_divisor  (SUM_W'(r_s_cnt)),
        .o_quotient (w_quo_y),
        .o_done     (w_done_y)
    );

    assign o_result_valid = r_result_valid;
    assign o_ball_found   = r_ball_found;
    assign o_ball_x       = r_ball_x;
    assign o_ball_y       = r_ball_y;
    assign o_ball_count   = r_ball_count;
    assign o_bbox_xmin    = r_bbox_xmin;
    assign o_bbox_xmax    = r_bbox_xmax;
    assign o_bbox_ymin    = r_bbox_ymin;
    assign o_bbox_ymax    = r_bbox_ymax;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_ball_centroid_acc.sv
// Scoreboard bench for ball_centroid_acc on an 8x4 frame: a frame-level reference model
// queues expected results, and a negedge monitor compares each published result.
module tb_ball_centroid_acc;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int NPIX = H * V;
    localparam int MINC = 2;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       fs = 1'b0;
    logic       pv = 1'b0;
    logic       inv = 1'b0;
    logic [8:0] hue = '0, hmin = '0, hmax = '0;
    logic [4:0] sat = '0, val = '0, smin = '0, vmin = '0;

    logic        o_result_valid, o_ball_found, o_overrun;
    logic [9:0]  o_ball_x, o_bbox_xmin, o_bbox_xmax;
    logic [8:0]  o_ball_y, o_bbox_ymin, o_bbox_ymax;
    logic [18:0] o_ball_count;

    typedef struct {
        int cnt;
        int found;
        int x;
        int y;
        int xmin;
        int xmax;
        int ymin;
        int ymax;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   f_h[NPIX];
    int   f_s[NPIX];
    int   f_v[NPIX];
    bit   f_inv[NPIX];
    int   n_checks = 0;
    int   n_pass = 0;

    // SUM_W widened so a division outlasts one back-to-back 32-pixel frame.
    ball_centroid_acc #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .X_W       (10),
        .Y_W       (9),
        .CNT_W     (19),
        .SUM_W     (40),
        .MIN_COUNT (MINC)
    ) dut (
        .i_clk          (clk),
        .i_res          (res),
        .i_frame_sync   (fs),
        .i_pix_valid    (pv),
        .i_hue          (hue),
        .i_saturation   (sat),
        .i_value        (val),
        .i_hue_invalid  (inv),
        .i_hue_min      (hmin),
        .i_hue_max      (hmax),
        .i_sat_min      (smin),
        .i_val_min      (vmin),
        .o_result_valid (o_result_valid),
        .o_ball_found   (o_ball_found),
        .o_ball_x       (o_ball_x),
        .o_ball_y       (o_ball_y),
        .o_ball_count   (o_ball_count),
        .o_bbox_xmin    (o_bbox_xmin),
        .o_bbox_xmax    (o_bbox_xmax),
        .o_bbox_ymin    (o_bbox_ymin),
        .o_bbox_ymax    (o_bbox_ymax),
        .o_overrun      (o_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic bit pix_match(input int p);
        bit in_win;
        if (int'(hmin) <= int'(hmax)) in_win = (f_h[p] >= int'(hmin)) && (f_h[p] <= int'(hmax));
        else in_win = (f_h[p] >= int'(hmin)) || (f_h[p] <= int'(hmax));
        return !f_inv[p] && (f_s[p] >= int'(smin)) && (f_v[p] >= int'(vmin)) && in_win;
    endfunction

    function automatic exp_t model_frame();
        exp_t e;
        int cnt = 0, sx = 0, sy = 0;
        int xmn = H, xmx = 0, ymn = V, ymx = 0;
        for (int p = 0; p < NPIX; p++) begin
            if (pix_match(p)) begin
                int x = p % H;
                int y = p / H;
                cnt++;
                sx += x;
                sy += y;
                if (x < xmn) xmn = x;
                if (x > xmx) xmx = x;
                if (y < ymn) ymn = y;
                if (y > ymx) ymx = y;
            end
        end
        e.cnt   = cnt;
        e.found = int'(cnt >= MINC);
        if (cnt == 0) begin
            e.x = 0; e.y = 0; e.xmin = 0; e.xmax = 0; e.ymin = 0; e.ymax = 0;
        end else begin
            e.x = sx / cnt; e.y = sy / cnt;
            e.xmin = xmn; e.xmax = xmx; e.ymin = ymn; e.ymax = ymx;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!res && o_result_valid) begin
            chk("result_expected", longint'(q.size() > 0), 1);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("count", o_ball_count, mon_e.cnt);
                chk("found", o_ball_found, mon_e.found);
                chk("ball_x", o_ball_x, mon_e.x);
                chk("ball_y", o_ball_y, mon_e.y);
                chk("bbox_xmin", o_bbox_xmin, mon_e.xmin);
                chk("bbox_xmax", o_bbox_xmax, mon_e.xmax);
                chk("bbox_ymin", o_bbox_ymin, mon_e.ymin);
                chk("bbox_ymax", o_bbox_ymax, mon_e.ymax);
            end
        end
    end

    task automatic set_window(input int lo, input int hi, input int sm, input int vm);
        hmin = 9'(lo); hmax = 9'(hi); smin = 5'(sm); vmin = 5'(vm);
    endtask

    task automatic fill(input int h, input int s, input int v, input bit iv);
        for (int p = 0; p < NPIX; p++) begin
            f_h[p] = h; f_s[p] = s; f_v[p] = v; f_inv[p] = iv;
        end
    endtask

    task automatic set_pix(input int x, input int y, input int h);
        f_h[y * H + x] = h;
    endtask

    task automatic drive(input bit f, input bit v, input int p);
        fs = f;
        pv = v;
        if (v) begin
            hue = 9'(f_h[p]); sat = 5'(f_s[p]); val = 5'(f_v[p]); inv = f_inv[p];
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 0);
    endtask

    task automatic feed(input int npix, input int gap_pct, input bit fs_first);
        for (int p = 0; p < npix; p++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) drive(1'b0, 1'b0, 0);
            drive(fs_first && (p == 0), 1'b1, p);
        end
        fs = 1'b0;
        pv = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int k = 0;
        while (q.size() != 0 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_valid"}, o_result_valid, 0);
        chk({tag, "_found"}, o_ball_found, 0);
        chk({tag, "_x"}, o_ball_x, 0);
        chk({tag, "_y"}, o_ball_y, 0);
        chk({tag, "_count"}, o_ball_count, 0);
        chk({tag, "_bbox"}, {o_bbox_xmin, o_bbox_xmax, o_bbox_ymin, o_bbox_ymax}, 0);
        chk({tag, "_overrun"}, o_overrun, 0);
    endtask

    task automatic ball_pattern();
        fill(0, 20, 20, 1'b0);
        set_pix(2, 1, 120); set_pix(3, 1, 120); set_pix(2, 2, 120); set_pix(3, 2, 120);
    endtask

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        res = 1'b0;
        check_cleared("reset");

        // Square blob in a plain window.
        set_window(100, 140, 8, 8);
        ball_pattern();
        q.push_back(model_frame());
        feed(NPIX, 20, 1'b0);
        wait_drain(200);
        idle(2);

        // Window wrapping through hue 0.
        set_window(340, 20, 8, 8);
        fill(180, 20, 20, 1'b0);
        set_pix(0, 0, 350); set_pix(7, 3, 10);
        q.push_back(model_frame());
        feed(NPIX, 20, 1'b0);
        wait_drain(200);
        idle(2);

        // All achromatic: empty result, published promptly.
        set_window(100, 140, 8, 8);
        fill(120, 20, 20, 1'b1);
        q.push_back(model_frame());
        feed(NPIX, 0, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 2 && !seen; k++) begin
            @(negedge clk);
            if (o_result_valid) seen = 1'b1;
        end
        chk("empty_publish_latency", seen, 1);
        wait_drain(50);
        idle(2);

        // Single match, below MIN_COUNT.
        fill(0, 20, 20, 1'b0);
        set_pix(5, 3, 120);
        q.push_back(model_frame());
        feed(NPIX, 20, 1'b0);
        wait_drain(200);
        idle(2);

        // Partial frame discarded by frame_sync arriving with the first pixel of a clean frame.
        ball_pattern();
        feed(20, 10, 1'b0);
        idle(3);
        fill(0, 20, 20, 1'b0);
        q.push_back(model_frame());
        feed(NPIX, 10, 1'b1);
        wait_drain(200);
        idle(2);

        // Random windows and pixels.
        for (int t = 0; t < 8; t++) begin
            set_window(int'($urandom_range(0, 359)), int'($urandom_range(0, 359)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            for (int p = 0; p < NPIX; p++) begin
                f_h[p]   = int'($urandom_range(0, 359));
                f_s[p]   = int'($urandom_range(0, 31));
                f_v[p]   = int'($urandom_range(0, 31));
                f_inv[p] = ($urandom_range(0, 9) == 0);
            end
            q.push_back(model_frame());
            feed(NPIX, 25, 1'b0);
            wait_drain(300);
            idle(2);
        end

        // Back-to-back frames: the second ends mid-division; only it is published.
        chk("overrun_clear_before", o_overrun, 0);
        set_window(100, 140, 8, 8);
        ball_pattern();
        feed(NPIX, 0, 1'b0);
        fill(0, 20, 20, 1'b0);
        set_pix(5, 3, 120);
        set_pix(1, 0, 130);
        q.push_back(model_frame());
        feed(NPIX, 0, 1'b0);
        wait_drain(300);
        idle(2);
        chk("overrun_set", o_overrun, 1);

        // Reset during a division: no result, everything cleared.
        ball_pattern();
        feed(NPIX, 0, 1'b0);
        idle(5);
        res = 1'b1;
        idle(2);
        res = 1'b0;
        idle(60);
        check_cleared("abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ball_centroid_acc.md
Name: ball_centroid_acc

Overview:
- Sits directly downstream of the RGB-to-HSV converter.
- Takes one HSV pixel per converter `done` pulse and classifies it against a programmable hue/saturation/value window.
- Accumulates the pixel count, coordinate sums and bounding box of matching ("ball") pixels over one frame.
- At frame end, computes the centroid with an iterative divider and publishes one result per frame to the tracking/servo logic.

Parameters:
- H_ACTIVE, 640, pixels per line.
- V_ACTIVE, 480, lines per frame.
- X_W, 10, x coordinate width; must satisfy 2^X_W >= H_ACTIVE.
- Y_W, 9, y coordinate width; must satisfy 2^Y_W >= V_ACTIVE.
- CNT_W, 19, match-count width; must satisfy 2^CNT_W > H_ACTIVE*V_ACTIVE.
- SUM_W, 29, coordinate-sum width; must satisfy 2^SUM_W > H_ACTIVE*H_ACTIVE*V_ACTIVE.
- MIN_COUNT, 16, minimum matching pixels for ball_found.

Ports:
- clk  in  1  system clock.
- res  in  1  synchronous active-high reset.
- frame_sync  in  1  one-cycle pulse at start of frame; discards the partial frame.
- pix_valid  in  1  one-cycle pixel strobe (converter done).
- hue  in  9  pixel hue.
- saturation  in  5  pixel saturation.
- value  in  5  pixel value.
- hue_invalid  in  1  pixel is achromatic; never matches.
- hue_min  in  9  window lower bound, inclusive.
- hue_max  in  9  window upper bound, inclusive.
- sat_min  in  5  minimum saturation, inclusive.
- val_min  in  5  minimum value, inclusive.
- result_valid  out  1  one-cycle pulse when the outputs below update.
- ball_found  out  1  match count >= MIN_COUNT.
- ball_x  out  X_W  centroid x, floor(sum_x/count).
- ball_y  out  Y_W  centroid y, floor(sum_y/count).
- ball_count  out  CNT_W  matching pixels in the frame.
- bbox_xmin, bbox_xmax  out  X_W  bounding box in x.
- bbox_ymin, bbox_ymax  out  Y_W  bounding box in y.
- overrun  out  1  sticky; a frame completed while a division was in progress.

Behaviour:
- Reset: all outputs 0. Internal state: x=0, y=0, accumulators cleared, state IDLE.
- Match condition, combinational on the pix_valid cycle:
  - !hue_invalid && saturation>=sat_min && value>=val_min, AND
  - hue in window: if hue_min<=hue_max, hue_min<=hue<=hue_max; otherwise (wrap through 0, e.g. red) hue>=hue_min || hue<=hue_max.
- Raster position:
  - Each pix_valid advances x.
  - At x==H_ACTIVE-1, x wraps to 0 and y increments.
  - The pixel at (H_ACTIVE-1, V_ACTIVE-1) is the frame-end pixel.
- Accumulation, registered on a matching pix_valid:
  - count+=1, sum_x+=x, sum_y+=y.
  - bbox mins/maxes update; the first match of a frame loads all four bbox values from that pixel.
- Frame end, on the cycle the frame-end pixel is accepted, including its contribution:
  - Snapshot count, sums and bbox into result-side registers.
  - Clear accumulators; x=y=0.
  - Next cycle: if snapshot count==0, go to PUBLISH. Otherwise start the divider and go to DIV.
  - Accumulation of the next frame continues in parallel with DIV.
- FSM:
  - IDLE -> DIV (count>0) or PUBLISH (count==0).
  - DIV: x and y quotients computed in parallel, SUM_W cycles, unsigned restoring division.
  - DIV -> PUBLISH when the divider asserts done.
  - PUBLISH -> IDLE after one cycle.
- PUBLISH cycle:
  - Outputs register, result_valid=1 for exactly one cycle.
  - ball_found = count>=MIN_COUNT.
  - When count==0: ball_x, ball_y and the bbox outputs are 0.
  - Outputs hold until the next PUBLISH.
- frame_sync:
  - Clears x, y and accumulators.
  - Does not affect DIV/PUBLISH or the published outputs.
  - frame_sync and pix_valid in the same cycle: clear first, then the pixel is processed at (0,0).
- Frame end while in DIV:
  - Set overrun.
  - Restart the divider with the new snapshot; the old result is never published.
  - overrun is cleared only by res.
- res mid-DIV: abort to IDLE, no result_valid.
- Arithmetic: unsigned throughout. Quotients are truncated to X_W/Y_W, which is safe since quotient <= max coordinate.

Decomposition:
- Shared package hsv_pkg:
  - width constants X_W, Y_W, CNT_W, SUM_W, plus HUE_W=9 and SV_W=5, shared with the converter.
  - state enum {IDLE, DIV, PUBLISH}.
- One sub-module seq_divider: unsigned restoring divider.
  - Generic width N.
  - Ports: clk, res, start, dividend, divisor, quotient, done.
  - N-cycle latency; restartable while busy.
  - Instantiated twice (x and y).

Test Plan (H_ACTIVE=8, V_ACTIVE=4, MIN_COUNT=2):
- Window hue 100..140, sat/val min 8. Matches at (2,1),(3,1),(2,2),(3,2) with hue=120,s=v=20, all other pixels hue=0. -> result_valid once, count=4, ball_x=2, ball_y=1, bbox (2,1)-(3,2), found=1.
- Wrap window hue_min=340, hue_max=20. Pixels hue=350 at (0,0), hue=10 at (7,3), hue=180 elsewhere. -> count=2, ball_x=3, ball_y=1, found=1.
- All pixels hue_invalid=1 -> result_valid within 2 cycles of frame end, count=0, found=0, all coords 0.
- Single match at (5,3) -> count=1, ball_x=5, ball_y=3, found=0.
- frame_sync after 20 pixels of a frame containing matches, then a full clean frame with no matches. -> published count=0, no contribution from the discarded pixels.
- Frame end delivered during DIV (back-to-back pix_valid every cycle, tiny frame) -> overrun=1, exactly one result_valid for the second frame. Then res -> overrun=0, all outputs 0.
